datapath_monitor: RTL and testbench

DATAPATH_MONITOR -- requirements
Module: datapath_monitor

---
 rtl/datapath_mon_pkg.sv | 39 +++
 rtl/sat_counter.sv | 52 +++++
 rtl/datapath_monitor.sv | 154 +++++++++++++++
 tb/tb_datapath_monitor.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/datapath_mon_pkg.sv
`default_nettype none
// ============================================================================
// Module      : datapath_mon_pkg
// Description : Shared types and constants for the datapath monitor.
//               Holds the opcode enumeration, the monitor FSM state type,
//               the bit positions of the sticky error vector and a small
//               helper that classifies result-producing (Y-modifying) ops.
// Revision    : 1.0 - initial release
// ============================================================================
package datapath_mon_pkg;

    // Datapath opcodes as seen on the Op bus.
    typedef enum logic [2:0] {
        OP_000 = 3'b000,
        OP_001 = 3'b001,
        OP_010 = 3'b010,    // flag-producing op: result bus must be stable
        OP_011 = 3'b011,
        OP_100 = 3'b100     // MOV: must never raise Flag on the next cycle
    } op_t;

    // Monitor FSM: IDLE (nothing awaited) / WAIT (result awaited).
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    // Bit positions inside the sticky err vector.
    localparam int ERR_TIMEOUT = 0;
    localparam int ERR_STABLE  = 1;
    localparam int ERR_MOVFLAG = 2;

    // True for ops that write the Y result and therefore start a wait.
    function automatic logic is_yop(input logic [2:0] op);
        return (op == OP_000) || (op == OP_001) ||
               (op == OP_011) || (op == OP_100);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : W-bit up counter that adds 0..3 per cycle and saturates at
//               2^W-1 instead of wrapping.
// Ports       : clk  - clock, rising edge
//               rst  - synchronous active-high reset
//               clr  - synchronous clear (same effect as rst)
//               inc  - amount to add this cycle (0..3)
//               cnt  - current count
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic [1:0]   inc,
    output logic [W-1:0] cnt
);

    // Sum is formed one bit wider than the larger operand so overflow past
    // the saturation value is visible even when W is smaller than inc.
    localparam int SW = ((W > 2) ? W : 2) + 1;
    localparam logic [SW-1:0] MAX_C = {{(SW-W){1'b0}}, {W{1'b1}}};

    logic [W-1:0]  cnt_q;
    logic [W-1:0]  cnt_d;
    logic [SW-1:0] w_sum;

    always_comb begin
        w_sum = {{(SW-W){1'b0}}, cnt_q} + {{(SW-2){1'b0}}, inc};
        if (w_sum > MAX_C) begin
            cnt_d = {W{1'b1}};
        end else begin
            cnt_d = w_sum[W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule
`default_nettype wire

// File: rtl/datapath_monitor.sv
`default_nettype none
// ============================================================================
// Module      : datapath_monitor
// Description : Passive checker for a small datapath. Tracks Y-modifying ops
//               and flags a timeout if no non-zero result appears within
//               TIMEOUT cycles, flags result-bus instability during flag ops,
//               and flags a Flag assertion on the cycle after a MOV write.
//               Errors are sticky; error and pass events are counted with
//               saturating counters.
// Ports       : clk, rst        - clock / synchronous active-high reset
//               OutPort         - datapath result bus (OUT_W bits)
//               Op, Wen, Flag   - datapath opcode, write enable, flag
//               clr             - synchronous clear of errors/counters/FSM
//               err             - sticky errors [0]timeout [1]stable [2]movflag
//               err_cnt         - total error events (saturating)
//               pass_cnt        - results delivered in time (saturating)
//               busy            - high while a result is awaited
// Revision    : 1.0 - initial release
// ============================================================================
module datapath_monitor
    import datapath_mon_pkg::*;
#(
    parameter int OUT_W   = 7,
    parameter int TIMEOUT = 100,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [OUT_W-1:0] OutPort,
    input  logic [2:0]       Op,
    input  logic             Wen,
    input  logic             Flag,
    input  logic             clr,
    output logic [2:0]       err,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] pass_cnt,
    output logic             busy
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] TIMEOUT_C = WAIT_W'(TIMEOUT);

    state_t             state_q, state_d;
    logic [WAIT_W-1:0]  wcnt_q, wcnt_d;
    logic [OUT_W-1:0]   prev_q;
    logic               prev_valid_q;
    logic               mov_pend_q;
    logic [2:0]         err_q, err_d;

    logic               w_ystart;
    logic               w_timeout_ev;
    logic               w_pass_ev;
    logic [2:0]         w_ev;
    logic [1:0]         w_err_inc;
    logic [1:0]         w_pass_inc;

    // ------------------------------------------------------------------
    // Wait FSM. A fresh Y-op (Wen=0) always restarts the wait, ahead of
    // the result and timeout checks for the same cycle.
    // ------------------------------------------------------------------
    always_comb begin
        w_ystart     = is_yop(Op) && !Wen;
        state_d      = state_q;
        wcnt_d       = wcnt_q;
        w_timeout_ev = 1'b0;
        w_pass_ev    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (w_ystart) begin
                    state_d = ST_WAIT;
                    wcnt_d  = '0;
                end
            end
            ST_WAIT: begin
                if (w_ystart) begin
                    wcnt_d = '0;
                end else if (|OutPort) begin
                    state_d   = ST_IDLE;
                    w_pass_ev = 1'b1;
                end else if (wcnt_q == TIMEOUT_C) begin
                    state_d      = ST_IDLE;
                    w_timeout_ev = 1'b1;
                end else begin
                    wcnt_d = wcnt_q + WAIT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                wcnt_d  = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Error events for this cycle. The stability check needs a valid
    // previous sample, which does not exist right after rst or clr.
    // ------------------------------------------------------------------
    always_comb begin
        w_ev              = 3'b000;
        w_ev[ERR_TIMEOUT] = w_timeout_ev;
        w_ev[ERR_STABLE]  = (Op == OP_010) && prev_valid_q && (OutPort != prev_q);
        w_ev[ERR_MOVFLAG] = mov_pend_q && Flag;
        err_d             = err_q | w_ev;
        w_err_inc         = {1'b0, w_ev[0]} + {1'b0, w_ev[1]} + {1'b0, w_ev[2]};
        w_pass_inc        = {1'b0, w_pass_ev};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            wcnt_q       <= '0;
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
            mov_pend_q   <= 1'b0;
            err_q        <= 3'b000;
        end else if (clr) begin
            state_q      <= ST_IDLE;
            wcnt_q       <= '0;
            prev_q       <= OutPort;
            prev_valid_q <= 1'b0;
            mov_pend_q   <= 1'b0;
            err_q        <= 3'b000;
        end else begin
            state_q      <= state_d;
            wcnt_q       <= wcnt_d;
            prev_q       <= OutPort;
            prev_valid_q <= 1'b1;
            mov_pend_q   <= (Op == OP_100) && Wen;
            err_q        <= err_d;
        end
    end

    // The counters take clr directly, so events in a clr cycle are dropped.
    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .inc (w_err_inc),
        .cnt (err_cnt)
    );

    sat_counter #(.W(CNT_W)) u_pass_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .inc (w_pass_inc),
        .cnt (pass_cnt)
    );

    assign err  = err_q;
    assign busy = (state_q == ST_WAIT);

endmodule
`default_nettype wire

// File: tb/tb_datapath_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_datapath_monitor
// Description : Directed self-checking bench. u_dut uses TIMEOUT=10 with
//               16-bit counters; u_sat uses TIMEOUT=2 with 2-bit counters to
//               reach saturation quickly. Both see the same stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_datapath_monitor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0;
    logic [6:0]  OutPort = 7'd0;
    logic [2:0]  Op = 3'b111;
    logic        Wen = 1'b0;
    logic        Flag = 1'b0;

    logic [2:0]  err;
    logic [15:0] err_cnt;
    logic [15:0] pass_cnt;
    logic        busy;

    logic [2:0]  s_err;
    logic [1:0]  s_err_cnt;
    logic [1:0]  s_pass_cnt;
    logic        s_busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    datapath_monitor #(.OUT_W(7), .TIMEOUT(10), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .OutPort(OutPort), .Op(Op), .Wen(Wen),
        .Flag(Flag), .clr(clr), .err(err), .err_cnt(err_cnt),
        .pass_cnt(pass_cnt), .busy(busy)
    );

    datapath_monitor #(.OUT_W(7), .TIMEOUT(2), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .OutPort(OutPort), .Op(Op), .Wen(Wen),
        .Flag(Flag), .clr(clr), .err(s_err), .err_cnt(s_err_cnt),
        .pass_cnt(s_pass_cnt), .busy(s_busy)
    );

    // One clock edge; outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        total++; if (err !== 3'b000) begin bad++; $display("FAIL reset_err: got %b want 000", err); end
        total++; if (err_cnt !== 16'd0 || pass_cnt !== 16'd0) begin bad++;
            $display("FAIL reset_cnt: got err_cnt=%0d pass_cnt=%0d want 0 0", err_cnt, pass_cnt); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        rst = 1'b0;
    endtask

    task automatic test_pass();
        int busy_cycles = 0;
        do_clr();
        OutPort = 7'd0; Op = 3'b000; Wen = 1'b0;
        step();
        if (busy === 1'b1) busy_cycles++;
        Op = 3'b111;
        for (int i = 0; i < 4; i++) begin
            step();
            if (busy === 1'b1) busy_cycles++;
        end
        OutPort = 7'h05;
        step();
        if (busy === 1'b1) busy_cycles++;
        total++; if (busy_cycles != 5) begin bad++; $display("FAIL pass_busy_cycles: got %0d want 5", busy_cycles); end
        total++; if (pass_cnt !== 16'd1) begin bad++; $display("FAIL pass_cnt: got %0d want 1", pass_cnt); end
        total++; if (err !== 3'b000) begin bad++; $display("FAIL pass_err: got %b want 000", err); end
        OutPort = 7'd0;
        step();
    endtask

    // A new Y-op in WAIT restarts the wait and wins over a result that
    // arrives in the same cycle.
    task automatic test_restart();
        Op = 3'b001; Wen = 1'b0; OutPort = 7'd0;
        step();
        Op = 3'b111;
        for (int i = 0; i < 5; i++) step();
        Op = 3'b000; OutPort = 7'd3;
        step();
        total++; if (busy !== 1'b1 || pass_cnt !== 16'd1) begin bad++;
            $display("FAIL restart_priority: got busy=%b pass_cnt=%0d want 1 1", busy, pass_cnt); end
        Op = 3'b111;
        step();
        total++; if (busy !== 1'b0 || pass_cnt !== 16'd2) begin bad++;
            $display("FAIL restart_pass: got busy=%b pass_cnt=%0d want 0 2", busy, pass_cnt); end
        OutPort = 7'd0;
        step();
    endtask

    task automatic test_timeout();
        do_clr();
        OutPort = 7'd0; Op = 3'b001; Wen = 1'b0;
        step();
        Op = 3'b111;
        for (int i = 0; i < 10; i++) step();
        total++; if (err !== 3'b000 || busy !== 1'b1) begin bad++;
            $display("FAIL timeout_early: got err=%b busy=%b want 000 1", err, busy); end
        step();
        total++; if (err !== 3'b001) begin bad++; $display("FAIL timeout_err: got %b want 001", err); end
        total++; if (err_cnt !== 16'd1 || busy !== 1'b0) begin bad++;
            $display("FAIL timeout_cnt: got err_cnt=%0d busy=%b want 1 0", err_cnt, busy); end
    endtask

    task automatic test_stable();
        OutPort = 7'd3; Op = 3'b111;
        do_clr();
        Op = 3'b010;
        for (int i = 0; i < 3; i++) step();
        total++; if (err !== 3'b000) begin bad++; $display("FAIL stable_const: got %b want 000", err); end
        OutPort = 7'd4;
        step();
        total++; if (err !== 3'b010 || err_cnt !== 16'd1) begin bad++;
            $display("FAIL stable_change: got err=%b err_cnt=%0d want 010 1", err, err_cnt); end
        step();
        step();
        total++; if (err_cnt !== 16'd1) begin bad++; $display("FAIL stable_hold: got %0d want 1", err_cnt); end
        // First cycle after clr has no valid previous value to compare.
        Op = 3'b111;
        do_clr();
        Op = 3'b010; OutPort = 7'd9;
        step();
        step();
        total++; if (err !== 3'b000) begin bad++; $display("FAIL stable_inhibit: got %b want 000", err); end
        Op = 3'b111; OutPort = 7'd0;
        step();
    endtask

    task automatic test_movflag();
        do_clr();
        OutPort = 7'd0; Op = 3'b100; Wen = 1'b1; Flag = 1'b0;
        step();
        Op = 3'b111; Wen = 1'b0; Flag = 1'b1;
        step();
        total++; if (err !== 3'b100 || err_cnt !== 16'd1) begin bad++;
            $display("FAIL mov_flag_set: got err=%b err_cnt=%0d want 100 1", err, err_cnt); end
        Flag = 1'b0;
        do_clr();
        Op = 3'b100; Wen = 1'b1;
        step();
        Op = 3'b111; Wen = 1'b0; Flag = 1'b0;
        step();
        total++; if (err !== 3'b000) begin bad++; $display("FAIL mov_flag_clear: got %b want 000", err); end
        Op = 3'b100; Wen = 1'b0;
        step();
        Op = 3'b111; Flag = 1'b1;
        step();
        total++; if (err[2] !== 1'b0) begin bad++; $display("FAIL mov_no_wen: got %b want 0", err[2]); end
        Flag = 1'b0;
        step();
    endtask

    // Timeout + MOV flag in one cycle, then instability + MOV flag.
    task automatic test_multi_error();
        do_clr();
        OutPort = 7'd0; Op = 3'b001; Wen = 1'b0;
        step();
        Op = 3'b111;
        for (int i = 0; i < 9; i++) step();
        Op = 3'b100; Wen = 1'b1;
        step();
        Op = 3'b010; Wen = 1'b0; Flag = 1'b1;
        step();
        total++; if (err !== 3'b101 || err_cnt !== 16'd2 || busy !== 1'b0) begin bad++;
            $display("FAIL multi_to_mov: got err=%b err_cnt=%0d busy=%b want 101 2 0", err, err_cnt, busy); end
        Op = 3'b100; Wen = 1'b1; Flag = 1'b0; OutPort = 7'd1;
        step();
        Op = 3'b010; Wen = 1'b0; Flag = 1'b1; OutPort = 7'd2;
        step();
        total++; if (err !== 3'b111 || err_cnt !== 16'd4) begin bad++;
            $display("FAIL multi_stable_mov: got err=%b err_cnt=%0d want 111 4", err, err_cnt); end
        Op = 3'b111; Flag = 1'b0; OutPort = 7'd0;
        step();
    endtask

    task automatic test_saturation();
        do_clr();
        OutPort = 7'd0; Wen = 1'b0;
        for (int n = 0; n < 5; n++) begin
            Op = 3'b001;
            step();
            Op = 3'b111;
            for (int i = 0; i < 3; i++) step();
            if (n == 2) begin
                total++; if (s_err_cnt !== 2'd3) begin bad++;
                    $display("FAIL sat_reach: got %0d want 3", s_err_cnt); end
            end
        end
        total++; if (s_err_cnt !== 2'd3 || s_err !== 3'b001) begin bad++;
            $display("FAIL sat_hold: got err_cnt=%0d err=%b want 3 001", s_err_cnt, s_err); end
        do_clr();
        total++; if (s_err !== 3'b000 || s_err_cnt !== 2'd0 || s_pass_cnt !== 2'd0 || s_busy !== 1'b0) begin bad++;
            $display("FAIL sat_clr: got err=%b err_cnt=%0d pass_cnt=%0d busy=%b want 000 0 0 0",
                     s_err, s_err_cnt, s_pass_cnt, s_busy); end
    endtask

    task automatic test_reset_in_wait();
        do_clr();
        OutPort = 7'd0; Op = 3'b001; Wen = 1'b0;
        step();
        Op = 3'b111;
        total++; if (busy !== 1'b1 || s_busy !== 1'b1) begin bad++;
            $display("FAIL rstwait_busy: got busy=%b s_busy=%b want 1 1", busy, s_busy); end
        step();
        rst = 1'b1; clr = 1'b1;
        step();
        rst = 1'b0; clr = 1'b0;
        total++; if (busy !== 1'b0 || err !== 3'b000 || s_busy !== 1'b0 || s_err !== 3'b000) begin bad++;
            $display("FAIL rstwait_abort: got busy=%b err=%b s_busy=%b s_err=%b want 0 000 0 000",
                     busy, err, s_busy, s_err); end
        for (int i = 0; i < 12; i++) step();
        total++; if (err !== 3'b000 || err_cnt !== 16'd0 || s_err !== 3'b000) begin bad++;
            $display("FAIL rstwait_noerr: got err=%b err_cnt=%0d s_err=%b want 000 0 000", err, err_cnt, s_err); end
    endtask

    initial begin
        test_reset();
        test_pass();
        test_restart();
        test_timeout();
        test_stable();
        test_movflag();
        test_multi_error();
        test_saturation();
        test_reset_in_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
